// File: rtl/lfsr_operand_gen.sv
// Operand generator for the 16-bit CLA add/sub stage: a Fibonacci LFSR feeds
// ain/bin/sub/cin vectors through a valid/ready handshake, num_vec per run.
module lfsr_operand_gen #(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             seed_load,
  input  logic [15:0]      seed_in,
  input  logic [7:0]       num_vec,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] ain,
  output logic [WIDTH-1:0] bin,
  output logic             sub,
  output logic             cin,
  output logic             busy,
  output logic             done,
  output logic [7:0]       vec_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GEN_A   = 3'd1,
    GEN_B   = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;
  logic [WIDTH-1:0] ain_q;
  logic [WIDTH-1:0] bin_q;
  logic             sub_q;
  logic             cin_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic [7:0]       num_q;

  // Taps for x^16+x^14+x^13+x^11+1.
  always_comb begin
    lfsr_d = {lfsr_q[WIDTH-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    cnt_d  = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      ain_q   <= '0;
      bin_q   <= '0;
      sub_q   <= 1'b0;
      cin_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      num_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= GEN_A;
            num_q   <= num_vec;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else if (seed_load) begin
            // A zero seed would lock the LFSR up, so fall back to SEED.
            lfsr_q <= (seed_in == '0) ? SEED : seed_in;
          end
        end
        GEN_A: begin
          ain_q   <= lfsr_d;
          lfsr_q  <= lfsr_d;
          state_q <= GEN_B;
        end
        GEN_B: begin
          bin_q   <= lfsr_d;
          lfsr_q  <= lfsr_d;
          sub_q   <= lfsr_d[0];
          cin_q   <= lfsr_d[1] & ~lfsr_d[0];
          valid_q <= 1'b1;
          state_q <= PRESENT;
        end
        PRESENT: begin
          if (ready_in) begin
            valid_q <= 1'b0;
            cnt_q   <= cnt_d;
            // num_vec of 0 means 256: the count wraps back to 0 and matches.
            if (cnt_d == num_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= GEN_A;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign valid_out = valid_q;
  assign ain       = ain_q;
  assign bin       = bin_q;
  assign sub       = sub_q;
  assign cin       = cin_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_cnt   = cnt_q;

endmodule

// File: tb/tb_lfsr_operand_gen.sv
// Directed bench for lfsr_operand_gen: a bench-side LFSR model fills a
// scoreboard of expected vectors that are popped as each vector is presented.
module tb_lfsr_operand_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic        c;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [7:0]  num_vec;
  logic        ready_in;
  logic        valid_out;
  logic [15:0] ain;
  logic [15:0] bin;
  logic        sub;
  logic        cin;
  logic        busy;
  logic        done;
  logic [7:0]  vec_cnt;

  int unsigned total;
  int unsigned passed;
  int unsigned done_cnt;
  logic [15:0] m;
  vec_t        sb[$];

  lfsr_operand_gen #(.SEED(SEED), .WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .num_vec   (num_vec),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .ain       (ain),
    .bin       (bin),
    .sub       (sub),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .vec_cnt   (vec_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference adder/subtractor: subtract is a + ~b + 1, add is a + b + cin.
  function automatic logic [16:0] cla_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input logic c);
    if (s) return {1'b0, a} + {1'b0, ~b} + 17'd1;
    return {1'b0, a} + {1'b0, b} + {16'd0, c};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One run: nv vectors (0 = 256), ready held low for 'stall' cycles on the
  // first vector, start/seed_load poked while busy before vector poke_at,
  // and optionally seed_load raised together with start.
  task automatic run(input int unsigned nv, input int unsigned stall,
                     input int poke_at, input bit both);
    int unsigned n;
    int unsigned lat;
    int unsigned d0;
    vec_t        e;
    logic [15:0] a;
    logic [15:0] b;
    n = (nv == 0) ? 256 : nv;
    for (int unsigned i = 0; i < n; i++) begin
      a = step(m);
      b = step(a);
      m = b;
      sb.push_back('{a: a, b: b, s: b[0], c: b[1] & ~b[0]});
    end
    d0        = done_cnt;
    ready_in  = (stall == 0);
    start     = 1'b1;
    num_vec   = nv[7:0];
    seed_load = both;
    seed_in   = 16'hBEEF;
    tick;
    start     = 1'b0;
    seed_load = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("vec_cnt_cleared", {24'd0, vec_cnt}, 32'd0);
    for (int unsigned v = 0; v < n; v++) begin
      if (poke_at >= 0 && v == poke_at) begin
        start     = 1'b1;
        seed_load = 1'b1;
        seed_in   = 16'h0001;
        num_vec   = 8'd1;
      end
      lat = 0;
      while (valid_out !== 1'b1 && lat < 10) begin
        tick;
        lat++;
      end
      start     = 1'b0;
      seed_load = 1'b0;
      // Two edges after the start/handshake edge: sampled high at edge k+3.
      chk("valid_latency", lat, 32'd2);
      e = sb.pop_front();
      chk("ain", {16'd0, ain}, {16'd0, e.a});
      chk("bin", {16'd0, bin}, {16'd0, e.b});
      chk("sub", {31'd0, sub}, {31'd0, e.s});
      chk("cin", {31'd0, cin}, {31'd0, e.c});
      chk("cla_result", {15'd0, cla_ref(ain, bin, sub, cin)},
          {15'd0, cla_ref(e.a, e.b, e.s, e.c)});
      chk("lfsr_nonzero", {31'd0, (ain != 16'd0) && (bin != 16'd0)}, 32'd1);
      if (v == 0 && stall > 0) begin
        for (int unsigned s = 0; s < stall; s++) begin
          tick;
          chk("stall_valid", {31'd0, valid_out}, 32'd1);
          chk("stall_ain", {16'd0, ain}, {16'd0, e.a});
          chk("stall_bin", {16'd0, bin}, {16'd0, e.b});
          chk("stall_subcin", {30'd0, sub, cin}, {30'd0, e.s, e.c});
        end
        ready_in = 1'b1;
      end
      tick;
      chk("vec_cnt", {24'd0, vec_cnt}, (v + 1) % 256);
      if (v + 1 < n) chk("valid_low_after_hs", {31'd0, valid_out}, 32'd0);
    end
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    tick;
    chk("done_cleared", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("done_once", done_cnt - d0, 32'd1);
    chk("vec_cnt_hold", {24'd0, vec_cnt}, n % 256);
    chk("sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    int unsigned d0;
    total     = 0;
    passed    = 0;
    done_cnt  = 0;
    m         = SEED;
    rst       = 1'b1;
    start     = 1'b0;
    seed_load = 1'b0;
    seed_in   = '0;
    num_vec   = '0;
    ready_in  = 1'b0;
    #2;
    chk("rst_outputs", {ain, bin}, 32'd0);
    chk("rst_flags", {27'd0, valid_out, sub, cin, busy, done}, 32'd0);
    chk("rst_vec_cnt", {24'd0, vec_cnt}, 32'd0);
    tick;
    rst = 1'b0;
    tick;

    // First vector from SEED, one-vector run.
    run(1, 0, -1, 1'b0);
    chk("first_ain_const", {16'd0, ain}, 32'h59C3);
    chk("first_bin_const", {16'd0, bin}, 32'hB387);
    chk("first_subcin_const", {30'd0, sub, cin}, 32'd2);

    // Backpressure on the first vector of a three-vector run.
    run(3, 5, -1, 1'b0);

    // Zero seed falls back to SEED.
    seed_load = 1'b1;
    seed_in   = 16'h0000;
    tick;
    seed_load = 1'b0;
    m = SEED;
    run(1, 0, -1, 1'b0);
    chk("zero_seed_ain", {16'd0, ain}, 32'h59C3);

    // Non-zero seed load, then start beats seed_load in the same cycle.
    seed_load = 1'b1;
    seed_in   = 16'h1234;
    tick;
    seed_load = 1'b0;
    m = 16'h1234;
    run(2, 0, -1, 1'b0);
    run(2, 0, -1, 1'b1);

    // Asynchronous reset while presenting: immediate clear, no done pulse.
    ready_in = 1'b0;
    num_vec  = 8'd1;
    start    = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("pre_rst_valid", {31'd0, valid_out}, 32'd1);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_outputs", {ain, bin}, 32'd0);
    chk("midrun_rst_flags", {27'd0, valid_out, sub, cin, busy, done}, 32'd0);
    chk("midrun_rst_vec_cnt", {24'd0, vec_cnt}, 32'd0);
    tick;
    rst      = 1'b0;
    ready_in = 1'b1;
    tick;
    tick;
    chk("midrun_rst_no_done", done_cnt - d0, 32'd0);
    m = SEED;
    run(1, 0, -1, 1'b0);
    chk("post_rst_ain", {16'd0, ain}, 32'h59C3);

    // 256-vector run with start/seed_load poked while busy.
    run(0, 0, 100, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
